fifo_bus_sel_arbiter: RTL and testbench



---
 rtl/fifo_bus_sel_arbiter.sv | 226 ++++++++++++++++++++++
 tb/tb_fifo_bus_sel_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_bus_sel_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_bus_sel_arbiter
//
// FIFO-side arbiter on the bus_sel interconnect. Frame detectors claim this
// FIFO by raising their bit of fifo_bus_sel. One requester is granted at a
// time, chosen round-robin, and it keeps the grant for one whole frame. The
// granted detector's words are buffered in a local FIFO. The one-hot grant is
// routed back to the detectors by the interconnect.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   fifo_bus_sel  per-detector request for this FIFO
//   fd_data       packed detector words, detector x at [x*DATA_W +: DATA_W]
//   fd_valid      per-detector word valid
//   fd_last       per-detector last-word-of-frame, qualified by fd_valid
//   grant         registered one-hot grant, or all zero
//   rd_en         pop request
//   rd_data       registered popped word
//   rd_valid      rd_data holds the word popped on the previous cycle
//   empty/full    registered occupancy flags
//   count         registered occupancy, 0..DEPTH
//   ovf_err       sticky: a word was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module fifo_bus_sel_arbiter #(
    parameter int PORT_NUM = 4,
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PORT_NUM-1:0]           fifo_bus_sel,
    input  logic [PORT_NUM*DATA_W-1:0]    fd_data,
    input  logic [PORT_NUM-1:0]           fd_valid,
    input  logic [PORT_NUM-1:0]           fd_last,
    output logic [PORT_NUM-1:0]           grant,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic                          empty,
    output logic                          full,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          ovf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int IW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Arbitration / frame control state
    state_t                state_q,      state_d;
    logic [PORT_NUM-1:0]   grant_q,      grant_d;
    logic [IW-1:0]         gidx_q,       gidx_d;
    logic [IW-1:0]         last_grant_q, last_grant_d;

    // FIFO state
    logic [DATA_W-1:0]     mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q;
    logic [AW-1:0]         rd_ptr_q;
    logic [CW-1:0]         count_q,      count_d;
    logic                  empty_q;
    logic                  full_q;
    logic [DATA_W-1:0]     rd_data_q;
    logic                  rd_valid_q;
    logic                  ovf_q;

    // Round-robin search results
    logic                  found;
    logic [IW-1:0]         win_idx;
    logic [IW-1:0]         cand;

    // Signals of the currently granted port
    logic                  sel_g;
    logic                  vld_g;
    logic                  last_g;
    logic [DATA_W-1:0]     data_g;

    // FIFO handshakes
    logic                  wr_req;
    logic                  push;
    logic                  pop;
    logic                  ovf_set;

    // -----------------------------------------------------------------------
    // Round-robin winner: first requester scanning upward from last_grant+1.
    // Offsets run 1..PORT_NUM so the previous owner is checked last.
    // -----------------------------------------------------------------------
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int i = 1; i <= PORT_NUM; i++) begin
            cand = IW'((int'(last_grant_q) + i) % PORT_NUM);
            if (!found && fifo_bus_sel[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    assign sel_g  = fifo_bus_sel[gidx_q];
    assign vld_g  = fd_valid[gidx_q];
    assign last_g = fd_last[gidx_q];
    assign data_g = fd_data[int'(gidx_q)*DATA_W +: DATA_W];

    // -----------------------------------------------------------------------
    // Frame FSM: next state, grant and write request
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        gidx_d       = gidx_q;
        last_grant_d = last_grant_q;
        wr_req       = 1'b0;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                // A full FIFO could not accept the frame, so hold off granting.
                if (found && !full_q) begin
                    state_d          = BUSY;
                    gidx_d           = win_idx;
                    grant_d[win_idx] = 1'b1;
                end
            end

            BUSY: begin
                if (!sel_g) begin
                    // Abort: requester withdrew, whatever it drives is discarded.
                    state_d      = IDLE;
                    grant_d      = '0;
                    last_grant_d = gidx_q;
                end else begin
                    wr_req = vld_g;
                    if (vld_g && last_g) begin
                        state_d      = IDLE;
                        grant_d      = '0;
                        last_grant_d = gidx_q;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO handshakes. A full FIFO still accepts a word when a pop frees a
    // slot in the same cycle; otherwise the word is dropped and flagged.
    // -----------------------------------------------------------------------
    assign pop     = rd_en && !empty_q;
    assign push    = wr_req && (!full_q || rd_en);
    assign ovf_set = wr_req && full_q && !rd_en;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // -----------------------------------------------------------------------
    // Control and output registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            gidx_q       <= '0;
            last_grant_q <= IW'(PORT_NUM - 1);
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            gidx_q       <= gidx_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            empty_q      <= (count_d == '0);
            full_q       <= (count_d == CW'(DEPTH));
            rd_valid_q   <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + AW'(1);
                rd_data_q <= mem[rd_ptr_q];
            end
            if (ovf_set) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= data_g;
        end
    end

    assign grant    = grant_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign empty    = empty_q;
    assign full     = full_q;
    assign count    = count_q;
    assign ovf_err  = ovf_q;

endmodule

// File: tb/tb_fifo_bus_sel_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for fifo_bus_sel_arbiter. Directed stimulus pushes the words that
// must come out of the FIFO into a queue; a negedge monitor pops and compares
// whenever rd_valid is high. Grant/flag checks are done directly.
// ---------------------------------------------------------------------------
module tb_fifo_bus_sel_arbiter;

    localparam int PN    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [PN-1:0]     fifo_bus_sel;
    logic [PN*DW-1:0]  fd_data;
    logic [PN-1:0]     fd_valid;
    logic [PN-1:0]     fd_last;
    logic [PN-1:0]     grant;
    logic              rd_en;
    logic [DW-1:0]     rd_data;
    logic              rd_valid;
    logic              empty;
    logic              full;
    logic [CW-1:0]     count;
    logic              ovf_err;

    logic [DW-1:0]     exp_q[$];
    logic [DW-1:0]     mon_exp;
    int                n_cmp = 0;
    int                n_err = 0;

    always #5 clk = ~clk;

    fifo_bus_sel_arbiter #(
        .PORT_NUM (PN),
        .DATA_W   (DW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_bus_sel (fifo_bus_sel),
        .fd_data      (fd_data),
        .fd_valid     (fd_valid),
        .fd_last      (fd_last),
        .grant        (grant),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .ovf_err      (ovf_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every word presented on the read port must match the queue head.
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got %0h expected no word (t=%0t)", rd_data, $time);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pop_data", {24'd0, rd_data}, {24'd0, mon_exp});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int p, input logic [DW-1:0] d);
        fd_data[p*DW +: DW] = d;
    endtask

    task automatic clear_inputs();
        fifo_bus_sel = '0;
        fd_data      = '0;
        fd_valid     = '0;
        fd_last      = '0;
        rd_en        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        repeat (n) step();
        rd_en = 1'b0;
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        chk("rst_grant",    grant,    0);
        chk("rst_rd_data",  rd_data,  0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_empty",    empty,    1);
        chk("rst_full",     full,     0);
        chk("rst_count",    count,    0);
        chk("rst_ovf",      ovf_err,  0);

        // Single frame on port 2: 0x11, 0x22, 0x33(last)
        fifo_bus_sel = 4'b0100;
        step();
        chk("sf_grant_c1", grant, 4'b0100);
        fd_valid = 4'b0100;
        set_word(2, 8'h11);
        step();
        chk("sf_grant_c2", grant, 4'b0100);
        chk("sf_count_1",  count, 1);
        chk("sf_empty_1",  empty, 0);
        set_word(2, 8'h22);
        step();
        chk("sf_grant_c3", grant, 4'b0100);
        set_word(2, 8'h33);
        fd_last = 4'b0100;
        step();
        chk("sf_grant_c4", grant, 4'b0000);
        chk("sf_count_3",  count, 3);
        clear_inputs();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        drain(3);
        chk("sf_empty_after", empty, 1);
        chk("sf_count_after", count, 0);
        rd_en = 1'b1;
        step();
        chk("sf_rd_empty_valid", rd_valid, 0);
        chk("sf_rd_empty_hold",  rd_data,  8'h33);
        rd_en = 1'b0;

        // Round-robin: ports 0,1,3 with continuous 1-word frames
        do_reset();
        fifo_bus_sel = 4'b1011;
        fd_valid     = 4'b1011;
        fd_last      = 4'b1011;
        set_word(0, 8'hA0);
        set_word(1, 8'hA1);
        set_word(3, 8'hA3);
        begin
            logic [PN-1:0] rr_exp [8];
            rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000,
                       4'b1000, 4'b0000, 4'b0001, 4'b0000};
            for (int i = 0; i < 8; i++) begin
                step();
                chk($sformatf("rr_grant_%0d", i), grant, rr_exp[i]);
            end
        end
        clear_inputs();
        chk("rr_count", count, 4);
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'hA1);
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'hA0);
        drain(4);

        // Overflow: 18-word frame, no reads
        do_reset();
        fifo_bus_sel = 4'b0001;
        step();
        chk("ov_grant", grant, 4'b0001);
        fd_valid = 4'b0001;
        for (int k = 1; k <= 18; k++) begin
            set_word(0, DW'(k));
            fd_last = (k == 18) ? 4'b0001 : 4'b0000;
            step();
            if (k <= 16) exp_q.push_back(DW'(k));
            if (k == 15) chk("ov_full_15", full, 0);
            if (k == 16) begin
                chk("ov_full_16",  full,    1);
                chk("ov_count_16", count,   16);
                chk("ov_ovf_16",   ovf_err, 0);
            end
            if (k == 17) begin
                chk("ov_ovf_17",   ovf_err, 1);
                chk("ov_grant_17", grant,   4'b0001);
                chk("ov_count_17", count,   16);
            end
        end
        chk("ov_grant_end", grant, 0);
        clear_inputs();
        repeat (3) step();
        chk("ov_ovf_sticky", ovf_err, 1);
        drain(16);
        chk("ov_ovf_after_drain", ovf_err, 1);
        chk("ov_empty_after",     empty,   1);

        // Full plus simultaneous pop
        do_reset();
        fifo_bus_sel = 4'b0001;
        step();
        fd_valid = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            set_word(0, DW'(8'h40 + k));
            exp_q.push_back(DW'(8'h40 + k));
            step();
        end
        chk("fp_full_before",  full,  1);
        chk("fp_count_before", count, 16);
        set_word(0, 8'hAA);
        fd_last = 4'b0001;
        rd_en   = 1'b1;
        exp_q.push_back(8'hAA);
        step();
        clear_inputs();
        chk("fp_count", count,   16);
        chk("fp_ovf",   ovf_err, 0);
        chk("fp_grant", grant,   0);
        chk("fp_full",  full,    1);
        drain(16);
        chk("fp_empty_after", empty, 1);

        // Abort: port 1 granted, withdraws after two words
        do_reset();
        fifo_bus_sel = 4'b0110;
        step();
        chk("ab_grant_p1", grant, 4'b0010);
        fd_valid = 4'b0110;
        set_word(1, 8'h51);
        set_word(2, 8'hEE);
        step();
        set_word(1, 8'h52);
        step();
        chk("ab_grant_hold", grant, 4'b0010);
        fifo_bus_sel = 4'b0100;
        set_word(1, 8'h99);
        step();
        chk("ab_grant_off", grant, 0);
        chk("ab_count",     count, 2);
        step();
        chk("ab_grant_p2", grant, 4'b0100);
        fifo_bus_sel = 4'b0000;
        fd_valid     = 4'b0000;
        step();
        chk("ab_grant_p2_off", grant, 0);
        chk("ab_count_final",  count, 2);
        exp_q.push_back(8'h51);
        exp_q.push_back(8'h52);
        drain(2);

        // Reset mid-frame
        do_reset();
        fifo_bus_sel = 4'b1000;
        step();
        chk("rm_grant_p3", grant, 4'b1000);
        fd_valid = 4'b1000;
        for (int k = 0; k < 5; k++) begin
            set_word(3, DW'(8'h61 + k));
            step();
        end
        chk("rm_count_5", count, 5);
        chk("rm_busy",    grant, 4'b1000);
        rst          = 1'b1;
        fd_valid     = 4'b0000;
        fifo_bus_sel = 4'b1001;
        step();
        rst = 1'b0;
        chk("rm_grant", grant,   0);
        chk("rm_count", count,   0);
        chk("rm_empty", empty,   1);
        chk("rm_ovf",   ovf_err, 0);
        step();
        chk("rm_first_p0", grant, 4'b0001);
        fifo_bus_sel = 4'b0000;
        step();
        chk("rm_abort", grant, 0);
        repeat (2) step();

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
